// File: rtl/maze_sprite_mover.sv
// Frame-paced square-sprite mover: one-pixel collision probes through a shared
// req/ack wall-lookup port, with playfield clamping, a gate and overrun flag.
module maze_sprite_mover #(
   parameter int         W         = 10,
   parameter int         SIZE      = 4,
   parameter int         STEP      = 1,
   parameter int         X_CENTER  = 340,
   parameter int         Y_CENTER  = 458,
   parameter int         X_MIN     = 0,
   parameter int         X_MAX     = 639,
   parameter int         Y_MIN     = 0,
   parameter int         Y_MAX     = 479,
   parameter int         GATE_Y    = 17,
   parameter int         GATE_X1   = 277,
   parameter int         GATE_X2   = 300,
   parameter int         CONT_MODE = 0,
   parameter logic [7:0] KEY_L     = 8'h04,
   parameter logic [7:0] KEY_R     = 8'h07,
   parameter logic [7:0] KEY_D     = 8'h16,
   parameter logic [7:0] KEY_U     = 8'h1A
) (
   input  logic         Clk,
   input  logic         Reset_n,
   input  logic         frame_tick,
   input  logic [7:0]   keycode,
   input  logic         gate_closed,
   output logic         wall_req,
   output logic [W-1:0] wall_x,
   output logic [W-1:0] wall_y,
   input  logic         wall_ack,
   input  logic         wall_hit,
   output logic [W-1:0] BallX,
   output logic [W-1:0] BallY,
   output logic [W-1:0] BallS,
   output logic         busy,
   output logic         blocked,
   output logic         frame_overrun,
   output logic [2:0]   o_dbg_state
);

   // Wall lookup handshake: wall_req rises on entry to PROBE with wall_x/wall_y
   // already stable; both hold until wall_ack=1 is sampled on a Clk edge, and
   // wall_req drops in the following cycle. wall_hit is only looked at with wall_ack.
   typedef enum logic [2:0] {S_IDLE, S_CHECK, S_PROBE, S_MOVE, S_DONE} state_t;
   typedef enum logic [2:0] {D_NONE, D_L, D_R, D_U, D_D} dir_t;

   localparam int            W1     = W + 1;
   localparam logic [W-1:0]  L_S1W  = W'(SIZE + 1);
   localparam logic [W1-1:0] L_S1   = W1'(SIZE + 1);
   localparam logic [W1-1:0] L_X_LO = W1'(X_MIN + SIZE + 1);
   localparam logic [W1-1:0] L_Y_LO = W1'(Y_MIN + SIZE + 1);
   localparam logic [W1-1:0] L_X_HI = W1'(X_MAX);
   localparam logic [W1-1:0] L_Y_HI = W1'(Y_MAX);
   localparam logic [W1-1:0] L_GY   = W1'(GATE_Y);
   localparam logic [W1-1:0] L_GX1  = W1'(GATE_X1);
   localparam logic [W1-1:0] L_GX2  = W1'(GATE_X2);
   localparam logic [3:0]    L_STEP = 4'(STEP);

   state_t        r_state;
   state_t        w_state_nxt;
   dir_t          r_dir;
   dir_t          w_tick_dir;
   logic [W-1:0]  r_x;
   logic [W-1:0]  r_y;
   logic [W-1:0]  r_px;
   logic [W-1:0]  r_py;
   logic [3:0]    r_n;
   logic [3:0]    w_n_inc;
   logic          r_blocked;
   logic          r_overrun;
   logic          w_edge_blk;
   logic [W-1:0]  w_probe_x;
   logic [W-1:0]  w_probe_y;
   logic [W1-1:0] w_x1;
   logic [W1-1:0] w_y1;
   logic [W1-1:0] w_hi_x;
   logic [W1-1:0] w_hi_y;
   logic [W1-1:0] w_lo_y;

   assign w_x1    = {1'b0, r_x};
   assign w_y1    = {1'b0, r_y};
   assign w_hi_x  = w_x1 + L_S1;
   assign w_hi_y  = w_y1 + L_S1;
   assign w_lo_y  = w_y1 - L_S1;
   assign w_n_inc = r_n + 4'd1;

   // Keys outside the direction set either stop the sprite or keep it coasting.
   always_comb begin
      w_tick_dir = (CONT_MODE != 0) ? r_dir : D_NONE;
      if (keycode == KEY_L)      w_tick_dir = D_L;
      else if (keycode == KEY_R) w_tick_dir = D_R;
      else if (keycode == KEY_U) w_tick_dir = D_U;
      else if (keycode == KEY_D) w_tick_dir = D_D;
   end

   // Leading-edge pixel one beyond the sprite, plus bound and gate tests done
   // one bit wider so the edges of the playfield never wrap.
   always_comb begin
      w_edge_blk = 1'b0;
      w_probe_x  = r_x;
      w_probe_y  = r_y;
      case (r_dir)
         D_L: begin
            w_edge_blk = (w_x1 < L_X_LO);
            w_probe_x  = r_x - L_S1W;
         end
         D_R: begin
            w_edge_blk = (w_hi_x > L_X_HI);
            w_probe_x  = w_hi_x[W-1:0];
         end
         D_U: begin
            w_edge_blk = (w_y1 < L_Y_LO) ||
                         (gate_closed && (w_lo_y <= L_GY) &&
                          (w_x1 >= L_GX1) && (w_x1 <= L_GX2));
            w_probe_y  = w_lo_y[W-1:0];
         end
         D_D: begin
            w_edge_blk = (w_hi_y > L_Y_HI);
            w_probe_y  = w_hi_y[W-1:0];
         end
         default: ;
      endcase
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (frame_tick && (w_tick_dir != D_NONE)) w_state_nxt = S_CHECK;
         S_CHECK: w_state_nxt = w_edge_blk ? S_DONE : S_PROBE;
         S_PROBE: if (wall_ack) w_state_nxt = wall_hit ? S_DONE : S_MOVE;
         S_MOVE:  w_state_nxt = (w_n_inc == L_STEP) ? S_DONE : S_CHECK;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_state   <= S_IDLE;
         r_x       <= W'(X_CENTER);
         r_y       <= W'(Y_CENTER);
         r_dir     <= D_NONE;
         r_n       <= '0;
         r_px      <= '0;
         r_py      <= '0;
         r_blocked <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (frame_tick && (r_state != S_IDLE)) r_overrun <= 1'b1;
         case (r_state)
            S_IDLE: begin
               if (frame_tick) begin
                  r_dir <= w_tick_dir;
                  if (w_tick_dir != D_NONE) begin
                     r_n       <= '0;
                     r_blocked <= 1'b0;
                  end
               end
            end
            S_CHECK: begin
               r_px <= w_probe_x;
               r_py <= w_probe_y;
               if (w_edge_blk) r_blocked <= 1'b1;
            end
            S_PROBE: if (wall_ack && wall_hit) r_blocked <= 1'b1;
            S_MOVE: begin
               r_n <= w_n_inc;
               case (r_dir)
                  D_L:     r_x <= r_x - W'(1);
                  D_R:     r_x <= r_x + W'(1);
                  D_U:     r_y <= r_y - W'(1);
                  D_D:     r_y <= r_y + W'(1);
                  default: ;
               endcase
            end
            // A coasting sprite that runs into something stops until a new key.
            S_DONE: if ((CONT_MODE != 0) && r_blocked) r_dir <= D_NONE;
            default: ;
         endcase
      end
   end

   assign wall_req      = (r_state == S_PROBE);
   assign wall_x        = r_px;
   assign wall_y        = r_py;
   assign BallX         = r_x;
   assign BallY         = r_y;
   assign BallS         = W'(SIZE);
   assign busy          = (r_state != S_IDLE);
   assign blocked       = r_blocked;
   assign frame_overrun = r_overrun;
   assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_maze_sprite_mover.sv
// Bench for maze_sprite_mover: two instances (STEP=1 held-key, STEP=4 coasting)
// against a per-frame reference model, wall-lookup responder and probe scoreboard.
module tb_maze_sprite_mover;

   logic             Clk = 1'b0;
   logic             Reset_n = 1'b0;
   logic             frame_tick = 1'b0;
   logic [7:0]       keycode = 8'h00;
   logic             gate_closed = 1'b0;
   logic [1:0]       wall_req;
   logic [1:0][9:0]  wall_x, wall_y;
   logic [1:0]       wall_ack = '0;
   logic [1:0]       wall_hit = '0;
   logic [1:0][9:0]  BallX, BallY, BallS;
   logic [1:0]       busy, blocked, ovr;
   logic [1:0][2:0]  dbg;

   int vectors = 0;
   int miscompares = 0;

   // Environment knobs
   int   wall_mode = 0;
   int   ack_delay = 0;
   bit   hold_ack = 1'b0;
   bit   force_ack = 1'b0;
   int   req_cnt[2];
   int   wait_cnt[2];
   logic [1:0] req_prev = '0;

   // Reference model state and probe scoreboards
   int   m_x[2], m_y[2], m_dir[2];
   bit   m_blk[2];
   logic [19:0] exp_q0[$], exp_q1[$], obs_q0[$], obs_q1[$];

   always #5 Clk = ~Clk;

   maze_sprite_mover u_dut0 (
      .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick), .keycode(keycode),
      .gate_closed(gate_closed), .wall_req(wall_req[0]), .wall_x(wall_x[0]),
      .wall_y(wall_y[0]), .wall_ack(wall_ack[0]), .wall_hit(wall_hit[0]),
      .BallX(BallX[0]), .BallY(BallY[0]), .BallS(BallS[0]), .busy(busy[0]),
      .blocked(blocked[0]), .frame_overrun(ovr[0]), .o_dbg_state(dbg[0])
   );

   maze_sprite_mover #(.STEP(4), .CONT_MODE(1)) u_dut1 (
      .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick), .keycode(keycode),
      .gate_closed(gate_closed), .wall_req(wall_req[1]), .wall_x(wall_x[1]),
      .wall_y(wall_y[1]), .wall_ack(wall_ack[1]), .wall_hit(wall_hit[1]),
      .BallX(BallX[1]), .BallY(BallY[1]), .BallS(BallS[1]), .busy(busy[1]),
      .blocked(blocked[1]), .frame_overrun(ovr[1]), .o_dbg_state(dbg[1])
   );

   function automatic bit is_wall(input int x, input int y);
      if (wall_mode == 0) return 1'b0;
      if (wall_mode == 1) return 1'b1;
      return ((x * 3 + y * 5) % 11) == 0;
   endfunction

   // Wall ROM stand-in: answers each request after ack_delay idle cycles.
   always @(negedge Clk) begin
      for (int i = 0; i < 2; i++) begin
         if (wall_req[i] && !req_prev[i]) req_cnt[i]++;
         req_prev[i] = wall_req[i];
         wall_ack[i] = 1'b0;
         if (wall_req[i] && !hold_ack) begin
            if (wait_cnt[i] >= ack_delay) begin
               wall_ack[i] = 1'b1;
               wall_hit[i] = is_wall(int'(wall_x[i]), int'(wall_y[i]));
               if (i == 0) obs_q0.push_back({wall_x[i], wall_y[i]});
               else        obs_q1.push_back({wall_x[i], wall_y[i]});
               wait_cnt[i] = 0;
            end else begin
               wait_cnt[i]++;
            end
         end else begin
            wait_cnt[i] = 0;
         end
         if (force_ack) begin
            wall_ack[i] = 1'b1;
            wall_hit[i] = 1'b0;
         end
      end
   end

   initial begin
      #900_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_x[i] = 340; m_y[i] = 458; m_dir[i] = 0; m_blk[i] = 1'b0;
      end
   endtask

   // One frame of sprite motion as the game rules describe it:
   // dir 0=none 1=left 2=right 3=up 4=down.
   task automatic model_frame(input int i, input logic [7:0] k, input logic g);
      int  steps, px, py;
      bit  stop;
      steps = (i == 0) ? 1 : 4;
      case (k)
         8'h04:   m_dir[i] = 1;
         8'h07:   m_dir[i] = 2;
         8'h1A:   m_dir[i] = 3;
         8'h16:   m_dir[i] = 4;
         default: if (i == 0) m_dir[i] = 0;
      endcase
      if (m_dir[i] != 0) begin
         m_blk[i] = 1'b0;
         stop = 1'b0;
         for (int n = 0; n < steps; n++) begin
            if (!stop) begin
               px = m_x[i]; py = m_y[i];
               case (m_dir[i])
                  1:       px = px - 5;
                  2:       px = px + 5;
                  3:       py = py - 5;
                  default: py = py + 5;
               endcase
               if (px < 0 || px > 639 || py < 0 || py > 479 ||
                   (m_dir[i] == 3 && g && py <= 17 && m_x[i] >= 277 && m_x[i] <= 300)) begin
                  m_blk[i] = 1'b1; stop = 1'b1;
               end else begin
                  if (i == 0) exp_q0.push_back({10'(px), 10'(py)});
                  else        exp_q1.push_back({10'(px), 10'(py)});
                  if (is_wall(px, py)) begin
                     m_blk[i] = 1'b1; stop = 1'b1;
                  end else begin
                     case (m_dir[i])
                        1:       m_x[i] = m_x[i] - 1;
                        2:       m_x[i] = m_x[i] + 1;
                        3:       m_y[i] = m_y[i] - 1;
                        default: m_y[i] = m_y[i] + 1;
                     endcase
                  end
               end
            end
         end
         if (i == 1 && m_blk[i]) m_dir[i] = 0;
      end
   endtask

   task automatic do_reset();
      @(negedge Clk);
      Reset_n = 1'b0;
      repeat (2) @(negedge Clk);
      Reset_n = 1'b1;
      model_reset();
   endtask

   // Pulse frame_tick, advance the model and wait (bounded) for both to go idle.
   task automatic run_frame(input logic [7:0] k, input logic g);
      int c;
      exp_q0.delete(); exp_q1.delete(); obs_q0.delete(); obs_q1.delete();
      @(negedge Clk);
      keycode = k; gate_closed = g; frame_tick = 1'b1;
      @(negedge Clk);
      frame_tick = 1'b0;
      model_frame(0, k, g);
      model_frame(1, k, g);
      c = 0;
      while (busy != 2'b00 && c < 400) begin
         @(negedge Clk);
         c++;
      end
      if (busy != 2'b00) begin
         vectors++; miscompares++;
         $display("FAIL frame_timeout: busy=%b after %0d cycles, want 00", busy, c);
      end
   endtask

   task automatic test_reset();
      Reset_n = 1'b0;
      repeat (3) @(negedge Clk);
      Reset_n = 1'b1;
      model_reset();
      @(negedge Clk);
      for (int i = 0; i < 2; i++) begin
         vectors++;
         if (BallX[i] !== 10'd340) begin miscompares++; $display("FAIL reset_x[%0d]: got %0d want 340", i, BallX[i]); end
         vectors++;
         if (BallY[i] !== 10'd458) begin miscompares++; $display("FAIL reset_y[%0d]: got %0d want 458", i, BallY[i]); end
         vectors++;
         if (BallS[i] !== 10'd4) begin miscompares++; $display("FAIL reset_s[%0d]: got %0d want 4", i, BallS[i]); end
         vectors++;
         if ({busy[i], blocked[i], ovr[i], wall_req[i]} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_flags[%0d]: busy/blocked/ovr/req got %b want 0000", i, {busy[i], blocked[i], ovr[i], wall_req[i]});
         end
      end
   endtask

   task automatic test_right();
      wall_mode = 0; ack_delay = 1;
      for (int f = 0; f < 3; f++) begin
         run_frame(8'h07, 1'b0);
         if (f == 0) begin
            vectors++;
            if (obs_q0.size() != 1 || obs_q0[0] !== {10'd345, 10'd458}) begin
               miscompares++;
               $display("FAIL right_first_probe: got %0d probes, first x=%0d want 1 probe at x=345 y=458",
                        obs_q0.size(), (obs_q0.size() > 0) ? obs_q0[0][19:10] : 10'd0);
            end
         end
      end
      vectors++;
      if (BallX[0] !== 10'd343) begin miscompares++; $display("FAIL right_x0: got %0d want 343", BallX[0]); end
      vectors++;
      if (blocked[0] !== 1'b0) begin miscompares++; $display("FAIL right_blocked0: got %b want 0", blocked[0]); end
      vectors++;
      if (BallX[1] !== 10'(m_x[1])) begin miscompares++; $display("FAIL right_x1: got %0d want %0d", BallX[1], m_x[1]); end
   endtask

   task automatic test_wall_hit();
      int rc0;
      wall_mode = 1; ack_delay = 0;
      rc0 = req_cnt[0];
      run_frame(8'h04, 1'b0);
      vectors++;
      if (BallX[0] !== 10'd343) begin miscompares++; $display("FAIL hit_x0: got %0d want 343", BallX[0]); end
      vectors++;
      if (blocked[0] !== 1'b1) begin miscompares++; $display("FAIL hit_blocked0: got %b want 1", blocked[0]); end
      vectors++;
      if (req_cnt[0] - rc0 != 1) begin miscompares++; $display("FAIL hit_req_pulses: got %0d want 1", req_cnt[0] - rc0); end
      vectors++;
      if (blocked[1] !== 1'b1 || BallX[1] !== 10'(m_x[1])) begin
         miscompares++;
         $display("FAIL hit_inst1: blocked=%b x=%0d want blocked=1 x=%0d", blocked[1], BallX[1], m_x[1]);
      end
      wall_mode = 0;
   endtask

   task automatic test_random();
      logic [7:0] keys [6];
      logic [7:0] k;
      keys[0] = 8'h04; keys[1] = 8'h07; keys[2] = 8'h1A;
      keys[3] = 8'h16; keys[4] = 8'h00; keys[5] = 8'h55;
      wall_mode = 2;
      for (int f = 0; f < 40; f++) begin
         k = keys[$urandom_range(0, 5)];
         ack_delay = $urandom_range(0, 2);
         run_frame(k, 1'($urandom_range(0, 1)));
         for (int i = 0; i < 2; i++) begin
            vectors++;
            if (BallX[i] !== 10'(m_x[i]) || BallY[i] !== 10'(m_y[i])) begin
               miscompares++;
               $display("FAIL rand_pos[%0d] frame %0d: got (%0d,%0d) want (%0d,%0d)", i, f, BallX[i], BallY[i], m_x[i], m_y[i]);
            end
            vectors++;
            if (blocked[i] !== m_blk[i]) begin
               miscompares++;
               $display("FAIL rand_blocked[%0d] frame %0d: got %b want %b", i, f, blocked[i], m_blk[i]);
            end
         end
         vectors++;
         if (obs_q0.size() != exp_q0.size()) begin
            miscompares++;
            $display("FAIL rand_probes0 frame %0d: got %0d probes want %0d", f, obs_q0.size(), exp_q0.size());
         end else begin
            for (int p = 0; p < exp_q0.size(); p++) begin
               vectors++;
               if (obs_q0[p] !== exp_q0[p]) begin
                  miscompares++;
                  $display("FAIL rand_probe0 frame %0d #%0d: got %h want %h", f, p, obs_q0[p], exp_q0[p]);
               end
            end
         end
         vectors++;
         if (obs_q1.size() != exp_q1.size()) begin
            miscompares++;
            $display("FAIL rand_probes1 frame %0d: got %0d probes want %0d", f, obs_q1.size(), exp_q1.size());
         end else begin
            for (int p = 0; p < exp_q1.size(); p++) begin
               vectors++;
               if (obs_q1[p] !== exp_q1[p]) begin
                  miscompares++;
                  $display("FAIL rand_probe1 frame %0d #%0d: got %h want %h", f, p, obs_q1[p], exp_q1[p]);
               end
            end
         end
      end
      wall_mode = 0;
   endtask

   task automatic test_cont_down();
      int rc1;
      do_reset();
      wall_mode = 0; ack_delay = 0;
      run_frame(8'h16, 1'b0);
      for (int f = 0; f < 4; f++) begin
         run_frame(8'h00, 1'b0);
         vectors++;
         if (BallY[1] !== 10'(m_y[1])) begin miscompares++; $display("FAIL cont_y frame %0d: got %0d want %0d", f, BallY[1], m_y[1]); end
      end
      vectors++;
      if (BallY[1] !== 10'd475 || blocked[1] !== 1'b1) begin
         miscompares++;
         $display("FAIL cont_stop: y=%0d blocked=%b want y=475 blocked=1", BallY[1], blocked[1]);
      end
      rc1 = req_cnt[1];
      repeat (3) run_frame(8'h00, 1'b0);
      vectors++;
      if (BallY[1] !== 10'd475 || req_cnt[1] != rc1) begin
         miscompares++;
         $display("FAIL cont_cleared: y=%0d extra_reqs=%0d want y=475 extra_reqs=0", BallY[1], req_cnt[1] - rc1);
      end
      vectors++;
      if (BallY[0] !== 10'd459) begin miscompares++; $display("FAIL cont_inst0_y: got %0d want 459", BallY[0]); end
   endtask

   task automatic test_gate();
      int rc0;
      do_reset();
      wall_mode = 0; ack_delay = 0;
      for (int f = 0; f < 500 && m_y[0] != 22; f++) run_frame(8'h1A, 1'b0);
      for (int f = 0; f < 100 && m_x[0] != 290; f++) run_frame(8'h04, 1'b0);
      vectors++;
      if (BallX[0] !== 10'd290 || BallY[0] !== 10'd22) begin
         miscompares++;
         $display("FAIL gate_setup: got (%0d,%0d) want (290,22)", BallX[0], BallY[0]);
      end
      rc0 = req_cnt[0];
      run_frame(8'h1A, 1'b1);
      vectors++;
      if (req_cnt[0] != rc0) begin miscompares++; $display("FAIL gate_no_req: got %0d requests want 0", req_cnt[0] - rc0); end
      vectors++;
      if (BallY[0] !== 10'd22 || blocked[0] !== 1'b1) begin
         miscompares++;
         $display("FAIL gate_closed: y=%0d blocked=%b want y=22 blocked=1", BallY[0], blocked[0]);
      end
      run_frame(8'h1A, 1'b0);
      vectors++;
      if (BallY[0] !== 10'd21 || blocked[0] !== 1'b0) begin
         miscompares++;
         $display("FAIL gate_open: y=%0d blocked=%b want y=21 blocked=0", BallY[0], blocked[0]);
      end
      vectors++;
      if (BallX[1] !== 10'(m_x[1]) || BallY[1] !== 10'(m_y[1])) begin
         miscompares++;
         $display("FAIL gate_inst1: got (%0d,%0d) want (%0d,%0d)", BallX[1], BallY[1], m_x[1], m_y[1]);
      end
   endtask

   task automatic test_overrun();
      do_reset();
      wall_mode = 0; hold_ack = 1'b1;
      @(negedge Clk); keycode = 8'h07; frame_tick = 1'b1;
      @(negedge Clk); frame_tick = 1'b0;
      repeat (3) @(negedge Clk);
      vectors++;
      if (wall_req !== 2'b11 || busy !== 2'b11 || ovr !== 2'b00) begin
         miscompares++;
         $display("FAIL ovr_waiting: req=%b busy=%b ovr=%b want 11 11 00", wall_req, busy, ovr);
      end
      frame_tick = 1'b1;
      @(negedge Clk); frame_tick = 1'b0;
      @(negedge Clk);
      vectors++;
      if (ovr !== 2'b11) begin miscompares++; $display("FAIL ovr_flag: got %b want 11", ovr); end
      vectors++;
      if (BallX[0] !== 10'd340 || BallX[1] !== 10'd340) begin
         miscompares++;
         $display("FAIL ovr_pos: x0=%0d x1=%0d want 340 340", BallX[0], BallX[1]);
      end
      #2 Reset_n = 1'b0;
      #1;
      vectors++;
      if (wall_req !== 2'b00 || busy !== 2'b00 || ovr !== 2'b00) begin
         miscompares++;
         $display("FAIL async_reset_flags: req=%b busy=%b ovr=%b want 00 00 00", wall_req, busy, ovr);
      end
      vectors++;
      if (BallX[0] !== 10'd340 || BallY[0] !== 10'd458 || BallX[1] !== 10'd340 || BallY[1] !== 10'd458) begin
         miscompares++;
         $display("FAIL async_reset_pos: (%0d,%0d) (%0d,%0d) want (340,458)", BallX[0], BallY[0], BallX[1], BallY[1]);
      end
      @(negedge Clk);
      Reset_n = 1'b1; hold_ack = 1'b0; force_ack = 1'b1;
      model_reset();
      repeat (3) @(negedge Clk);
      force_ack = 1'b0;
      vectors++;
      if (busy !== 2'b00 || dbg[0] !== 3'd0 || dbg[1] !== 3'd0 || BallX[0] !== 10'd340) begin
         miscompares++;
         $display("FAIL late_ack: busy=%b state0=%0d state1=%0d x0=%0d want 00 0 0 340", busy, dbg[0], dbg[1], BallX[0]);
      end
      run_frame(8'h07, 1'b0);
      vectors++;
      if (BallX[0] !== 10'd341 || BallX[1] !== 10'(m_x[1])) begin
         miscompares++;
         $display("FAIL recover: x0=%0d x1=%0d want 341 %0d", BallX[0], BallX[1], m_x[1]);
      end
   endtask

   initial begin
      req_cnt[0] = 0; req_cnt[1] = 0;
      wait_cnt[0] = 0; wait_cnt[1] = 0;
      model_reset();
      test_reset();
      test_right();
      test_wall_hit();
      test_random();
      test_cont_down();
      test_gate();
      test_overrun();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
